// File: rtl/dil_stream_pkg.sv
// Shared types for the Dilithium input sequencer: field ids, mode encodings and per-field bit sizes.
package dil_stream_pkg;

  typedef enum logic [3:0] {
    FLD_SEED = 4'd0,
    FLD_RHO  = 4'd1,
    FLD_KEY  = 4'd2,
    FLD_TR   = 4'd3,
    FLD_S1   = 4'd4,
    FLD_S2   = 4'd5,
    FLD_T0   = 4'd6,
    FLD_T1   = 4'd7,
    FLD_C    = 4'd8,
    FLD_Z    = 4'd9,
    FLD_H    = 4'd10,
    FLD_MSG  = 4'd11
  } field_e;

  localparam logic [1:0] MODE_KEYGEN = 2'b00;
  localparam logic [1:0] MODE_SIGN   = 2'b10;
  localparam logic [1:0] MODE_VERIFY = 2'b01;

  // Largest field (Z at level 5, 35840 bits) fits in 16 bits.
  localparam int FB_W = 16;

  function automatic logic [FB_W-1:0] field_bits(input field_e f, input logic [2:0] sec,
                                                 input logic [FB_W-1:0] msg_len);
    logic [FB_W-1:0] b;
    b = 16'd256;
    case (f)
      FLD_S1:  b = (sec == 3'd2) ? 16'd3072  : (sec == 3'd3) ? 16'd5120  : 16'd5376;
      FLD_S2:  b = (sec == 3'd2) ? 16'd3072  : 16'd6144;
      FLD_T0:  b = (sec == 3'd2) ? 16'd13312 : (sec == 3'd3) ? 16'd19968 : 16'd26624;
      FLD_T1:  b = (sec == 3'd2) ? 16'd10240 : (sec == 3'd3) ? 16'd15360 : 16'd20480;
      FLD_Z:   b = (sec == 3'd2) ? 16'd18432 : (sec == 3'd3) ? 16'd25600 : 16'd35840;
      FLD_H:   b = (sec == 3'd2) ? 16'd672   : (sec == 3'd3) ? 16'd488   : 16'd664;
      FLD_MSG: b = msg_len;
      default: b = 16'd256;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dil_field_lut.sv
// Ordered field list per mode: maps a list index to its field id and flags the final entry.
module dil_field_lut
  import dil_stream_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [2:0] idx,
  output field_e     field,
  output logic       last
);

  always_comb begin
    field = FLD_SEED;
    last  = 1'b1;
    case (mode)
      MODE_SIGN: begin
        case (idx)
          3'd0:    field = FLD_RHO;
          3'd1:    field = FLD_KEY;
          3'd2:    field = FLD_TR;
          3'd3:    field = FLD_S1;
          3'd4:    field = FLD_S2;
          3'd5:    field = FLD_T0;
          default: field = FLD_MSG;
        endcase
        last = (idx >= 3'd6);
      end
      MODE_VERIFY: begin
        case (idx)
          3'd0:    field = FLD_RHO;
          3'd1:    field = FLD_T1;
          3'd2:    field = FLD_C;
          3'd3:    field = FLD_Z;
          3'd4:    field = FLD_H;
          default: field = FLD_MSG;
        endcase
        last = (idx >= 3'd5);
      end
      default: begin
        field = FLD_SEED;
        last  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dil_field_streamer.sv
// Walks the field list of the selected Dilithium mode, tagging upstream words for the core.
// Optional FIELD_MASK_EN zeroes the padding bits of each field's final partial word.
module dil_field_streamer
  import dil_stream_pkg::*;
#(
  parameter int W         = 64,
  parameter int MSG_LEN_W = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic [2:0]           sec_level_i,
  input  logic [MSG_LEN_W-1:0] msg_len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  input  logic [W-1:0]         s_data_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  output logic [W-1:0]         m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [3:0]           m_field_o,
  output logic                 m_last_field_o,
  output logic                 m_last_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_e;

  state_e               state_q;
  logic [1:0]           mode_q;
  logic [2:0]           sec_q;
  logic [MSG_LEN_W-1:0] msg_len_q;
  logic [2:0]           idx_q;
  logic [FB_W-1:0]      rem_q;
  logic                 last_loaded_q;

  field_e cur_field, nxt_field;
  logic   cur_last, nxt_last;
  logic   legal, field_last_word, seq_end, xfer;
  logic [W-1:0] word_in;

  dil_field_lut u_cur_lut (.mode(mode_q), .idx(idx_q),        .field(cur_field), .last(cur_last));
  dil_field_lut u_nxt_lut (.mode(mode_q), .idx(idx_q + 3'd1), .field(nxt_field), .last(nxt_last));

  assign legal = (mode_i != 2'b11) &&
                 ((sec_level_i == 3'd2) || (sec_level_i == 3'd3) || (sec_level_i == 3'd5));

  // rem_q counts bits still owed by the current field, so no division is needed for word counts.
  assign field_last_word = (rem_q <= FB_W'(W));
  assign seq_end   = cur_last || (nxt_field == FLD_MSG && nxt_last && msg_len_q == '0);
  assign s_ready_o = (state_q == S_STREAM) && !last_loaded_q && (!m_valid_o || m_ready_i);
  assign xfer      = s_valid_i && s_ready_o;

`ifdef FIELD_MASK_EN
  function automatic logic [W-1:0] tail_mask(input logic [FB_W-1:0] nbits);
    logic [W-1:0] m;
    for (int i = 0; i < W; i++) m[i] = (i < int'(nbits));
    return m;
  endfunction

  assign word_in = field_last_word ? (s_data_i & tail_mask(rem_q)) : s_data_i;
`else
  assign word_in = s_data_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      mode_q         <= '0;
      sec_q          <= '0;
      msg_len_q      <= '0;
      idx_q          <= '0;
      rem_q          <= '0;
      last_loaded_q  <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      m_data_o       <= '0;
      m_valid_o      <= 1'b0;
      m_field_o      <= '0;
      m_last_field_o <= 1'b0;
      m_last_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (legal) begin
              mode_q    <= mode_i;
              sec_q     <= sec_level_i;
              msg_len_q <= msg_len_i;
              idx_q     <= '0;
              busy_o    <= 1'b1;
              state_q   <= S_LOAD;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          rem_q         <= field_bits(cur_field, sec_q, FB_W'(msg_len_q));
          last_loaded_q <= 1'b0;
          state_q       <= S_STREAM;
        end
        S_STREAM: begin
          if (xfer) begin
            m_data_o       <= word_in;
            m_valid_o      <= 1'b1;
            m_field_o      <= cur_field;
            m_last_field_o <= field_last_word;
            m_last_o       <= field_last_word && seq_end;
            if (field_last_word) begin
              if (seq_end) begin
                last_loaded_q <= 1'b1;
              end else begin
                idx_q <= idx_q + 3'd1;
                rem_q <= field_bits(nxt_field, sec_q, FB_W'(msg_len_q));
              end
            end else begin
              rem_q <= rem_q - FB_W'(W);
            end
          end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
          end
          if (last_loaded_q && m_valid_o && m_ready_i) begin
            done_o  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dil_field_streamer.sv
// Scoreboard bench for dil_field_streamer: reference word list built from the field-size tables.
module tb_dil_field_streamer;

  localparam int W = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  mode_i = 2'b00;
  logic [2:0]  sec_level_i = 3'd0;
  logic [14:0] msg_len_i = '0;
  logic        busy_o, done_o, err_o;
  logic [63:0] s_data_i = '0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [63:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i = 1'b0;
  logic [3:0]  m_field_o;
  logic        m_last_field_o, m_last_o;

  dil_field_streamer #(.W(W), .MSG_LEN_W(15)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i), .sec_level_i(sec_level_i),
    .msg_len_i(msg_len_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_field_o(m_field_o), .m_last_field_o(m_last_field_o), .m_last_o(m_last_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    int          f;
    bit          lf;
    bit          l;
  } exp_t;

  exp_t        q[$];
  logic [63:0] arr[2048];
  int          ptr = 0;
  bit          fire_prev = 1'b0;
  bit          rnd_mode = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          acc_cnt = 0;
  int          exp_total = 0;
  bit          saw_t0 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Field sizes in bits; ids: SEED0 RHO1 KEY2 TR3 S1 4 S2 5 T0 6 T1 7 C8 Z9 H10 MSG11.
  function automatic int fbits(input int f, input int sec, input int msg);
    int li;
    int s1[3] = '{3072, 5120, 5376};
    int s2[3] = '{3072, 6144, 6144};
    int t0[3] = '{13312, 19968, 26624};
    int t1[3] = '{10240, 15360, 20480};
    int z[3]  = '{18432, 25600, 35840};
    int h[3]  = '{672, 488, 664};
    li = (sec == 2) ? 0 : (sec == 3) ? 1 : 2;
    case (f)
      4: return s1[li];
      5: return s2[li];
      6: return t0[li];
      7: return t1[li];
      9: return z[li];
      10: return h[li];
      11: return msg;
      default: return 256;
    endcase
  endfunction

  task automatic build_exp(input logic [1:0] m, input int sec, input int msg);
    int fl[$];
    int k, bits, nw, vb;
    exp_t e;
    logic [63:0] mask;
    q.delete();
    if (m == 2'b10)      fl = '{1, 2, 3, 4, 5, 6, 11};
    else if (m == 2'b01) fl = '{1, 7, 8, 9, 10, 11};
    else                 fl = '{0};
    if (fl[fl.size()-1] == 11 && msg == 0) void'(fl.pop_back());
    for (int i = 0; i < 2048; i++) arr[i] = {$urandom, $urandom};
    k = 0;
    for (int fi = 0; fi < fl.size(); fi++) begin
      bits = fbits(fl[fi], sec, msg);
      nw   = (bits + W - 1) / W;
      vb   = bits - (nw - 1) * W;
      for (int w = 0; w < nw; w++) begin
        e.d  = arr[k];
        e.f  = fl[fi];
        e.lf = (w == nw - 1);
        e.l  = e.lf && (fi == fl.size() - 1);
`ifdef FIELD_MASK_EN
        if (e.lf && vb < W) begin
          mask = (64'd1 << vb) - 64'd1;
          e.d  = e.d & mask;
        end
`endif
        q.push_back(e);
        k++;
      end
    end
    exp_total = k;
  endtask

  // Upstream source and downstream sink, optionally with random gaps/back-pressure.
  initial begin
    forever begin
      @(negedge clk);
      if (fire_prev) ptr++;
      s_valid_i = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_ready_i = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data_i  = arr[ptr % 2048];
      #2;
      fire_prev = s_valid_i && s_ready_o;
    end
  end

  // Monitor: pops the scoreboard on each accepted output word.
  initial begin
    bit          have_prev;
    bit          last_acc_prev;
    bit          acc;
    logic [63:0] prev_d;
    logic [6:0]  prev_tags;
    exp_t        e;
    have_prev = 1'b0;
    last_acc_prev = 1'b0;
    prev_d = '0;
    prev_tags = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        have_prev = 1'b0;
        last_acc_prev = 1'b0;
        continue;
      end
      if (have_prev) begin
        chk("stall_data", m_data_o, prev_d);
        chk("stall_tags", 64'({m_valid_o, m_field_o, m_last_field_o, m_last_o}), 64'(prev_tags));
      end
      if (done_o) chk("done_after_last", 64'(last_acc_prev), 64'd1);
      acc = m_valid_o && m_ready_i;
      if (acc) begin
        acc_cnt++;
        if (m_field_o == 4'd6) saw_t0 = 1'b1;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word actual=%h required=none", m_data_o);
        end else begin
          e = q.pop_front();
          chk("data", m_data_o, e.d);
          chk("tags", 64'({m_field_o, m_last_field_o, m_last_o}), 64'({4'(e.f), e.lf, e.l}));
        end
      end
      have_prev = m_valid_o && !m_ready_i;
      prev_d = m_data_o;
      prev_tags = {m_valid_o, m_field_o, m_last_field_o, m_last_o};
      last_acc_prev = acc && m_last_o;
    end
  end

  task automatic start_seq(input logic [1:0] m, input int sec, input int msg);
    @(negedge clk);
    #3;
    build_exp(m, sec, msg);
    ptr = 0;
    acc_cnt = 0;
    saw_t0 = 1'b0;
    @(negedge clk);
    mode_i = m;
    sec_level_i = 3'(sec);
    msg_len_i = 15'(msg);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 8000) begin
      @(negedge clk);
      #2;
      if (done_o) break;
      n++;
    end
    if (n >= 8000) chk({name, "_timeout"}, 64'd0, 64'd1);
    chk({name, "_busy_at_done"}, 64'(busy_o), 64'd1);
    chk({name, "_queue_empty"}, 64'(q.size()), 64'd0);
    chk({name, "_word_count"}, 64'(acc_cnt), 64'(exp_total));
    @(negedge clk);
    #2;
    chk({name, "_idle_after"}, 64'({busy_o, done_o}), 64'd0);
  endtask

  task automatic illegal_start(input string name, input logic [1:0] m, input logic [2:0] sec);
    @(negedge clk);
    mode_i = m;
    sec_level_i = sec;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    #2;
    chk({name, "_err"}, 64'({err_o, busy_o}), 64'b10);
    @(negedge clk);
    #2;
    chk({name, "_err_clear"}, 64'({err_o, busy_o}), 64'b00);
  endtask

  initial begin
    int m_sel, sec_sel, msg, n;
    logic [1:0] modes[3] = '{2'b00, 2'b10, 2'b01};
    int secs[3] = '{2, 3, 5};

    #23;
    chk("reset_ctrl", 64'({busy_o, done_o, err_o, s_ready_o, m_valid_o, m_field_o,
                           m_last_field_o, m_last_o}), 64'd0);
    chk("reset_data", m_data_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    rnd_mode = 1'b0;
    start_seq(2'b00, 2, 0);
    wait_done("keygen");
    start_seq(2'b10, 2, 264);
    wait_done("sign_s2");
    start_seq(2'b01, 3, 0);
    wait_done("verify_s3");

    illegal_start("mode11", 2'b11, 3'd2);
    illegal_start("sec4", 2'b10, 3'd4);

    rnd_mode = 1'b1;
    start_seq(2'b10, 5, 1000);
    repeat (20) @(negedge clk);
    mode_i = 2'b00;
    sec_level_i = 3'd2;
    start_i = 1'b1;
    @(negedge clk);
    mode_i = 2'b11;
    @(negedge clk);
    start_i = 1'b0;
    #2;
    chk("busy_start_err", 64'({err_o, busy_o}), 64'b01);
    wait_done("busy_start");

    for (int i = 0; i < 6; i++) begin
      m_sel = $urandom_range(0, 2);
      sec_sel = $urandom_range(0, 2);
      msg = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 26400);
      start_seq(modes[m_sel], secs[sec_sel], msg);
      wait_done("random");
    end

    start_seq(2'b10, 2, 500);
    n = 0;
    while (!saw_t0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("t0_reached", 64'(saw_t0), 64'd1);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 64'({busy_o, done_o, err_o, s_ready_o, m_valid_o, m_field_o,
                            m_last_field_o, m_last_o}), 64'd0);
    chk("midrst_data", m_data_o, 64'd0);
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start_seq(2'b10, 3, 777);
    wait_done("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
